// File: rtl/led_status_arbiter.sv
// ---------------------------------------------------------------------------
// led_status_arbiter
//
// Shares the board's green and red status LEDs between NUM_REQ requesters.
// Each requester supplies an 8-tick on/off pattern per LED. Ownership is
// decided by fixed priority (index 0 highest), and only at frame boundaries,
// so a frame that has started always plays to completion. When nobody
// requests, a heartbeat idle pattern plays instead.
//
// Parameters:
//   NUM_REQ    - number of requesters (>=1)
//   TICK_DIV   - clk cycles per pattern tick (>=2)
//   IDLE_GREEN - green pattern played while idle
//   IDLE_RED   - red pattern played while idle
//
// Ports:
//   clk       - sole clock, all state on posedge
//   rst_n     - asynchronous active-low reset
//   req       - level request per requester
//   pat_green - green patterns, requester i at [8*i+:8], bit k = on at tick k
//   pat_red   - red patterns, same packing
//   grant     - one-hot owner of the current frame, zero while idle
//   done      - one-cycle pulse to the owner when its frame completes
//   busy      - high while a requester-owned frame plays
//   LED_GREEN - active-low green LED drive
//   LED_RED   - active-low red LED drive
// ---------------------------------------------------------------------------
module led_status_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter int         TICK_DIV   = 1024,
  parameter logic [7:0] IDLE_GREEN = 8'b0000_0001,
  parameter logic [7:0] IDLE_RED   = 8'b0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] pat_green,
  input  logic [8*NUM_REQ-1:0] pat_red,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 LED_GREEN,
  output logic                 LED_RED
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        prescaler, prescaler_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [7:0]           snap_g, snap_r, snap_g_nxt, snap_r_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt, win_oh;
  logic                 busy_nxt, led_g_nxt, led_r_nxt;
  logic                 tick;
  logic [7:0]           win_g, win_r;

  assign tick = (prescaler == TICK_LAST);

  // Isolating the lowest set request bit gives the fixed-priority winner
  // directly as a one-hot vector, which is exactly what grant needs.
  assign win_oh = req & ((~req) + NUM_REQ'(1));

  // Select the winner's patterns; with no winner the idle heartbeat is the
  // natural default, so the snapshot load needs no separate idle branch.
  always_comb begin
    win_g = IDLE_GREEN;
    win_r = IDLE_RED;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_g = pat_green[8*i +: 8];
        win_r = pat_red[8*i +: 8];
      end
    end
  end

  // Next-state logic. Everything holds between ticks except done, which is
  // a pulse. A tick either advances within the frame or, on the last bit,
  // closes the frame, re-arbitrates and shows bit 0 of the new snapshot in
  // the same cycle so back-to-back frames have no gap.
  always_comb begin
    prescaler_nxt = tick ? '0 : prescaler + PW'(1);
    state_nxt     = state;
    bit_idx_nxt   = bit_idx;
    snap_g_nxt    = snap_g;
    snap_r_nxt    = snap_r;
    grant_nxt     = grant;
    busy_nxt      = busy;
    led_g_nxt     = LED_GREEN;
    led_r_nxt     = LED_RED;
    done_nxt      = '0;

    if (tick) begin
      if (bit_idx != 3'd7) begin
        bit_idx_nxt = bit_idx + 3'd1;
        led_g_nxt   = ~snap_g[bit_idx_nxt];
        led_r_nxt   = ~snap_r[bit_idx_nxt];
      end else begin
        if (state == PLAY) begin
          done_nxt = grant;
        end
        bit_idx_nxt = 3'd0;
        snap_g_nxt  = win_g;
        snap_r_nxt  = win_r;
        led_g_nxt   = ~win_g[0];
        led_r_nxt   = ~win_r[0];
        grant_nxt   = win_oh;
        busy_nxt    = |req;
        state_nxt   = (|req) ? PLAY : IDLE;
      end
    end
  end

  // State register. bit_idx resets to 7 so the very first tick is treated
  // as a frame boundary and arbitration starts cleanly with LEDs dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      bit_idx   <= 3'd7;
      snap_g    <= IDLE_GREEN;
      snap_r    <= IDLE_RED;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      LED_GREEN <= 1'b1;
      LED_RED   <= 1'b1;
    end else begin
      state     <= state_nxt;
      prescaler <= prescaler_nxt;
      bit_idx   <= bit_idx_nxt;
      snap_g    <= snap_g_nxt;
      snap_r    <= snap_r_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      LED_GREEN <= led_g_nxt;
      LED_RED   <= led_r_nxt;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_status_arbiter
//
// Bench for led_status_arbiter with NUM_REQ=4, TICK_DIV=4. Expected outputs
// come from a time-indexed reference: the cycle count since reset release
// determines how many ticks have elapsed, hence the frame number and the bit
// position; each frame's owner and patterns are recorded when its boundary
// edge arrives.
// ---------------------------------------------------------------------------
module tb_led_status_arbiter;

  localparam int         NUM_REQ  = 4;
  localparam int         TICK_DIV = 4;
  localparam int         FRAME    = 8 * TICK_DIV;
  localparam logic [7:0] IDLE_G   = 8'b0000_0001;
  localparam logic [7:0] IDLE_R   = 8'b0000_0000;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] pat_green;
  logic [8*NUM_REQ-1:0] pat_red;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic                 LED_GREEN;
  logic                 LED_RED;

  int         nChecks = 0;
  int         nFails  = 0;
  int         cyc     = 0;
  int         frameOwner[$];
  logic [7:0] frameG[$];
  logic [7:0] frameR[$];

  led_status_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .TICK_DIV   (TICK_DIV),
    .IDLE_GREEN (IDLE_G),
    .IDLE_RED   (IDLE_R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pat_green (pat_green),
    .pat_red   (pat_red),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .LED_GREEN (LED_GREEN),
    .LED_RED   (LED_RED)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVec(input string tag, input logic [NUM_REQ-1:0] got,
                          input logic [NUM_REQ-1:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nFails++;
      $error("[TB] FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic exp);
    nChecks++;
    assert (got === exp) else begin
      nFails++;
      $error("[TB] FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // Record owner and patterns as seen at a frame boundary edge.
  task automatic captureFrame();
    int owner;
    owner = -1;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) owner = i;
    end
    frameOwner.push_back(owner);
    if (owner >= 0) begin
      frameG.push_back(pat_green[8*owner +: 8]);
      frameR.push_back(pat_red[8*owner +: 8]);
    end else begin
      frameG.push_back(IDLE_G);
      frameR.push_back(IDLE_R);
    end
  endtask

  // Compare all outputs against the reference for the current cycle.
  task automatic checkOutput();
    logic               expG, expR, expBusy;
    logic [NUM_REQ-1:0] expGrant, expDone;
    logic [7:0]         pg, pr;
    int                 k, f, p;
    expG     = 1'b1;
    expR     = 1'b1;
    expBusy  = 1'b0;
    expGrant = '0;
    expDone  = '0;
    k = cyc / TICK_DIV;
    if (k > 0) begin
      f  = (k - 1) / 8;
      p  = (k - 1) % 8;
      pg = frameG[f];
      pr = frameR[f];
      expG = ~pg[p];
      expR = ~pr[p];
      if (frameOwner[f] >= 0) begin
        expGrant = NUM_REQ'(1 << frameOwner[f]);
        expBusy  = 1'b1;
      end
      if ((cyc % FRAME == TICK_DIV) && (f >= 1) && (frameOwner[f-1] >= 0)) begin
        expDone = NUM_REQ'(1 << frameOwner[f-1]);
      end
    end
    checkBit("led_green", LED_GREEN, expG);
    checkBit("led_red", LED_RED, expR);
    checkBit("busy", busy, expBusy);
    checkVec("grant", grant, expGrant);
    checkVec("done", done, expDone);
  endtask

  // Advance one clock: update the reference at the edge, check at negedge.
  task automatic stepCycle();
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      if (cyc % FRAME == TICK_DIV) captureFrame();
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runUntil(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] r,
                               input logic [8*NUM_REQ-1:0] pg,
                               input logic [8*NUM_REQ-1:0] pr);
    req       = r;
    pat_green = pg;
    pat_red   = pr;
  endtask

  // Assert reset between edges, check the asynchronous response, hold, then
  // release on a negedge so the next posedge is edge 1 of the new run.
  task automatic doReset(input int holdCycles);
    #2 rst_n = 1'b0;
    cyc = 0;
    frameOwner.delete();
    frameG.delete();
    frameR.delete();
    #1 checkOutput();
    repeat (holdCycles) stepCycle();
    rst_n = 1'b1;
    checkOutput();
  endtask

  initial begin
    logic [8*NUM_REQ-1:0] pg, pr;
    logic [NUM_REQ-1:0]   r;
    rst_n = 1'b1;
    applyStimulus('0, '0, '0);
    @(negedge clk);

    // Idle heartbeat after reset.
    $display("[TB] idle heartbeat");
    doReset(2);
    runUntil(4);
    checkBit("idle_bit0_green", LED_GREEN, 1'b0);
    runUntil(70);

    // Single requester, known patterns, held for three frames.
    $display("[TB] single requester, continuous");
    doReset(2);
    pg = $urandom;
    pr = $urandom;
    pg[23:16] = 8'hA5;
    pr[23:16] = 8'h0F;
    applyStimulus(4'b0100, pg, pr);
    runUntil(4);
    checkBit("s2_green_t0", LED_GREEN, 1'b0);
    checkBit("s2_red_t0", LED_RED, 1'b0);
    runUntil(20);
    checkBit("s2_green_t4", LED_GREEN, 1'b1);
    checkBit("s2_red_t4", LED_RED, 1'b1);
    runUntil(36);
    checkVec("s2_done_first", done, 4'b0100);
    runUntil(104);

    // Higher priority arrives mid-frame: no preemption.
    $display("[TB] late higher-priority request");
    applyStimulus(4'b1000, {$urandom}, {$urandom});
    runUntil(150);
    applyStimulus(4'b1001, {$urandom}, {$urandom});
    runUntil(164);
    checkVec("s3_done3", done, 4'b1000);
    checkVec("s3_grant0", grant, 4'b0001);
    runUntil(200);

    // Owner changes pattern and drops request mid-frame.
    $display("[TB] owner drops request mid-frame");
    applyStimulus(4'b0010, {$urandom}, {$urandom});
    runUntil(240);
    applyStimulus(4'b0000, ~pat_green, pat_red);
    runUntil(260);
    checkVec("s4_done1", done, 4'b0010);
    runUntil(300);

    // Reset in the middle of a played frame.
    $display("[TB] reset mid-frame");
    doReset(2);
    applyStimulus(4'b0100, {$urandom}, {$urandom});
    runUntil(25);
    doReset(3);
    runUntil(40);

    // Randomised traffic with occasional resets.
    $display("[TB] random traffic");
    for (int seg = 0; seg < 40; seg++) begin
      r = NUM_REQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      applyStimulus(r, {$urandom}, {$urandom});
      if ($urandom_range(0, 11) == 0) doReset($urandom_range(1, 3));
      repeat ($urandom_range(1, 40)) stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
